// File: rtl/jtaguart_mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtaguart_pkg
//  Description : Register map and STATUS/CTRL bit positions of the console port.
//  Revision    : 1.0
// ============================================================================
package jtaguart_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_addr_e;

    localparam int c_ST_TX_FULL    = 0;
    localparam int c_ST_TX_EMPTY   = 1;
    localparam int c_ST_RX_AVAIL   = 2;
    localparam int c_ST_TX_OVF     = 3;
    localparam int c_ST_RX_CNT_LSB = 8;
    localparam int c_ST_TX_CNT_LSB = 16;

    localparam int c_CTRL_RX_IE    = 0;
    localparam int c_CTRL_TXE_IE   = 1;
    localparam int c_CTRL_W        = 2;

endpackage
`default_nettype wire

// File: rtl/jtaguart_mmio_if.sv
`default_nettype none
// ============================================================================
//  Module      : jtaguart_mmio_if
//  Description : CPU bus plus UART-wrapper tx/rx handshakes of the console port.
//  Revision    : 1.0
// ============================================================================
interface jtaguart_mmio_if;
    logic [1:0]  bus_addr;
    logic        bus_wr;
    logic [31:0] bus_wdata;
    logic        bus_rd;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        irq;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;

    modport slave (
        input  bus_addr, bus_wr, bus_wdata, bus_rd, tx_ready, rx_valid, rx_data,
        output bus_rdata, bus_rvalid, irq, tx_valid, tx_data, rx_ready
    );

    modport master (
        output bus_addr, bus_wr, bus_wdata, bus_rd, tx_ready, rx_valid, rx_data,
        input  bus_rdata, bus_rvalid, irq, tx_valid, tx_data, rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/jtaguart_mmio_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with wrap-bit pointers; push/pop gated by
//                fullness/emptiness at the start of the cycle.
//  Revision    : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 4
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    i_push,
    input  wire  [WIDTH-1:0]       i_data,
    input  wire                    i_pop,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [LOG2_DEPTH:0]    o_count,
    output logic [WIDTH-1:0]       o_head
);
    localparam int c_DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]    r_mem [c_DEPTH];
    logic [LOG2_DEPTH:0] r_wr_ptr;
    logic [LOG2_DEPTH:0] r_rd_ptr;
    logic                w_do_push;
    logic                w_do_pop;

    // Same slot index with differing wrap bits means the writer lapped the reader.
    assign o_full    = (r_wr_ptr[LOG2_DEPTH-1:0] == r_rd_ptr[LOG2_DEPTH-1:0]) &&
                       (r_wr_ptr[LOG2_DEPTH] != r_rd_ptr[LOG2_DEPTH]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_head    = r_mem[r_rd_ptr[LOG2_DEPTH-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[LOG2_DEPTH-1:0]] <= i_data;
    end
endmodule
`default_nettype wire

// File: rtl/jtaguart_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : jtaguart_mmio
//  Description : Memory-mapped console port: TX/RX byte FIFOs in front of the
//                JTAG UART wrapper, DATA/STATUS/CTRL registers and an irq.
//  Revision    : 1.0
// ============================================================================
module jtaguart_mmio #(
    parameter int LOG2_TX_DEPTH = 4,
    parameter int LOG2_RX_DEPTH = 4
) (
    input  wire             clk,
    input  wire             rst,
    jtaguart_mmio_if.slave  bus
);
    import jtaguart_pkg::*;

    logic                     w_sel_data;
    logic                     w_sel_status;
    logic                     w_sel_ctrl;
    logic                     w_data_wr;
    logic                     w_data_rd;
    logic                     w_tx_full;
    logic                     w_tx_empty;
    logic [LOG2_TX_DEPTH:0]   w_tx_count;
    logic [7:0]               w_tx_head;
    logic                     w_rx_full;
    logic                     w_rx_empty;
    logic [LOG2_RX_DEPTH:0]   w_rx_count;
    logic [7:0]               w_rx_head;
    logic [31:0]              w_status;
    logic [31:0]              w_rd_mux;
    logic                     w_unused_wdata;

    logic                     r_tx_ovf;
    logic [c_CTRL_W-1:0]      r_ctrl;
    logic [31:0]              r_rdata;
    logic                     r_rvalid;
    logic                     r_irq;

    assign w_sel_data     = (bus.bus_addr == REG_DATA);
    assign w_sel_status   = (bus.bus_addr == REG_STATUS);
    assign w_sel_ctrl     = (bus.bus_addr == REG_CTRL);
    assign w_data_wr      = bus.bus_wr && w_sel_data;
    assign w_data_rd      = bus.bus_rd && w_sel_data;
    assign w_unused_wdata = &bus.bus_wdata[31:8];

    sync_fifo #(.WIDTH(8), .LOG2_DEPTH(LOG2_TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_data_wr),
        .i_data  (bus.bus_wdata[7:0]),
        .i_pop   (bus.tx_ready),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count),
        .o_head  (w_tx_head)
    );

    // An empty-FIFO DATA read must not pop; the FIFO itself gates on emptiness.
    sync_fifo #(.WIDTH(8), .LOG2_DEPTH(LOG2_RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.rx_valid),
        .i_data  (bus.rx_data),
        .i_pop   (w_data_rd),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count),
        .o_head  (w_rx_head)
    );

    assign bus.tx_valid   = !w_tx_empty;
    assign bus.tx_data    = w_tx_head;
    assign bus.rx_ready   = !w_rx_full;
    assign bus.bus_rdata  = r_rdata;
    assign bus.bus_rvalid = r_rvalid;
    assign bus.irq        = r_irq;

    always_comb begin
        w_status                           = '0;
        w_status[c_ST_TX_FULL]             = w_tx_full;
        w_status[c_ST_TX_EMPTY]            = w_tx_empty;
        w_status[c_ST_RX_AVAIL]            = !w_rx_empty;
        w_status[c_ST_TX_OVF]              = r_tx_ovf;
        w_status[c_ST_RX_CNT_LSB +: 8]     = 8'(w_rx_count);
        w_status[c_ST_TX_CNT_LSB +: 8]     = 8'(w_tx_count);
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.bus_addr)
            REG_DATA:   w_rd_mux = w_rx_empty ? 32'h0 : {1'b1, 23'b0, w_rx_head};
            REG_STATUS: w_rd_mux = w_status;
            REG_CTRL:   w_rd_mux = 32'(r_ctrl);
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_ovf <= 1'b0;
            r_ctrl   <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            // Set and clear come from different register writes, so they never collide.
            if (w_data_wr && w_tx_full)
                r_tx_ovf <= 1'b1;
            else if (bus.bus_wr && w_sel_status && bus.bus_wdata[c_ST_TX_OVF])
                r_tx_ovf <= 1'b0;

            if (bus.bus_wr && w_sel_ctrl)
                r_ctrl <= bus.bus_wdata[c_CTRL_W-1:0];

            r_rvalid <= bus.bus_rd;
            if (bus.bus_rd)
                r_rdata <= w_rd_mux;

            r_irq <= (r_ctrl[c_CTRL_RX_IE] && !w_rx_empty) ||
                     (r_ctrl[c_CTRL_TXE_IE] && w_tx_empty);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_jtaguart_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtaguart_mmio
//  Description : Self-checking bench for jtaguart_mmio against a queue model.
//  Revision    : 1.0
// ============================================================================
module tb_jtaguart_mmio;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jtaguart_mmio_if bus_if ();

    jtaguart_mmio #(.LOG2_TX_DEPTH(4), .LOG2_RX_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: byte queues plus the few architectural registers.
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_exp[$];
    logic [7:0]  tx_obs[$];
    logic        m_ovf;
    logic [1:0]  m_ctrl;
    logic        m_irq;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'h0;
        if (tx_q.size() == DEPTH) s = s + 32'd1;
        if (tx_q.size() == 0)     s = s + 32'd2;
        if (rx_q.size() != 0)     s = s + 32'd4;
        if (m_ovf)                s = s + 32'd8;
        s = s + 32'(rx_q.size()) * 32'd256;
        s = s + 32'(tx_q.size()) * 32'd65536;
        return s;
    endfunction

    // Advance one clock: update the model from the driven inputs and the
    // start-of-cycle FIFO occupancy, then sample 1 time unit after the edge.
    task automatic tick();
        logic        t_full, t_empty, r_full, r_empty;
        logic        n_irq, n_rvalid;
        logic [31:0] n_rdata;
        logic [1:0]  a;
        a       = bus_if.bus_addr;
        t_full  = (tx_q.size() == DEPTH);
        t_empty = (tx_q.size() == 0);
        r_full  = (rx_q.size() == DEPTH);
        r_empty = (rx_q.size() == 0);
        n_rdata = m_rdata;
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            m_ovf    = 1'b0;
            m_ctrl   = 2'b00;
            n_irq    = 1'b0;
            n_rvalid = 1'b0;
            n_rdata  = 32'h0;
        end else begin
            if (bus_if.tx_valid && bus_if.tx_ready) tx_obs.push_back(bus_if.tx_data);
            n_irq    = (m_ctrl[0] && !r_empty) || (m_ctrl[1] && t_empty);
            n_rvalid = bus_if.bus_rd;
            if (bus_if.bus_rd) begin
                case (a)
                    2'd0:    n_rdata = r_empty ? 32'h0 : (32'h8000_0000 | 32'(rx_q[0]));
                    2'd1:    n_rdata = model_status();
                    2'd2:    n_rdata = 32'(m_ctrl);
                    default: n_rdata = 32'h0;
                endcase
                if (a == 2'd0 && !r_empty) void'(rx_q.pop_front());
            end
            if (bus_if.rx_valid && !r_full) rx_q.push_back(bus_if.rx_data);
            if (bus_if.tx_ready && !t_empty) tx_exp.push_back(tx_q.pop_front());
            if (bus_if.bus_wr) begin
                case (a)
                    2'd0: begin
                        if (t_full) m_ovf = 1'b1;
                        else        tx_q.push_back(bus_if.bus_wdata[7:0]);
                    end
                    2'd1:    if (bus_if.bus_wdata[3]) m_ovf = 1'b0;
                    2'd2:    m_ctrl = bus_if.bus_wdata[1:0];
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        m_irq    = n_irq;
        m_rvalid = n_rvalid;
        m_rdata  = n_rdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.bus_wr    = 1'b1;
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        tick();
        bus_if.bus_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic v);
        bus_if.bus_rd   = 1'b1;
        bus_if.bus_addr = a;
        tick();
        bus_if.bus_rd   = 1'b0;
        d = bus_if.bus_rdata;
        v = bus_if.bus_rvalid;
    endtask

    task automatic rx_inject(input logic [7:0] b);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        tick();
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks += 5;
        if (bus_if.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", bus_if.tx_valid); end
        if (bus_if.rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b exp=1", bus_if.rx_ready); end
        if (bus_if.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus_if.irq); end
        if (bus_if.bus_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", bus_if.bus_rvalid); end
        if (bus_if.bus_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus_if.bus_rdata); end
    endtask

    task automatic test_tx_order();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        tx_obs.delete();
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) bus_write(2'd0, {24'h0, exp_b[i]});
        repeat (3) tick();
        checks++;
        if (tx_obs.size() != 3) begin failures++; $display("FAIL tx_order_count got=%0d exp=3", tx_obs.size()); end
        for (int i = 0; i < 3 && i < tx_obs.size(); i++) begin
            checks++;
            if (tx_obs[i] !== exp_b[i]) begin failures++; $display("FAIL tx_order_byte%0d got=%h exp=%h", i, tx_obs[i], exp_b[i]); end
        end
        checks++;
        if (bus_if.tx_valid !== 1'b0) begin failures++; $display("FAIL tx_order_idle got=%b exp=0", bus_if.tx_valid); end
    endtask

    task automatic test_tx_full();
        logic [7:0]  b [17];
        logic [31:0] d;
        logic        v;
        bus_if.tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b[i] = 8'($urandom);
            bus_write(2'd0, {24'($urandom), b[i]});
        end
        bus_read(2'd1, d, v);
        checks += 3;
        if (v !== 1'b1) begin failures++; $display("FAIL txfull_rvalid got=%b exp=1", v); end
        if (d !== 32'h0010_0009) begin failures++; $display("FAIL txfull_status got=%h exp=00100009", d); end
        if (d !== m_rdata) begin failures++; $display("FAIL txfull_status_model got=%h exp=%h", d, m_rdata); end
        bus_write(2'd1, 32'h0000_0008);
        bus_read(2'd1, d, v);
        checks++;
        if (d !== 32'h0010_0001) begin failures++; $display("FAIL txovf_clear got=%h exp=00100001", d); end
        tx_obs.delete();
        bus_if.tx_ready = 1'b1;
        repeat (20) tick();
        checks++;
        if (tx_obs.size() != 16) begin failures++; $display("FAIL txfull_drain_count got=%0d exp=16", tx_obs.size()); end
        for (int i = 0; i < 16 && i < tx_obs.size(); i++) begin
            checks++;
            if (tx_obs[i] !== b[i]) begin failures++; $display("FAIL txfull_drain_byte%0d got=%h exp=%h", i, tx_obs[i], b[i]); end
        end
        checks++;
        if (bus_if.tx_valid !== 1'b0) begin failures++; $display("FAIL txfull_drained got=%b exp=0", bus_if.tx_valid); end
    endtask

    task automatic test_rx_read();
        logic [31:0] exp_d [3];
        logic [31:0] d;
        logic        v;
        exp_d[0] = 32'h8000_0055; exp_d[1] = 32'h8000_00AA; exp_d[2] = 32'h0;
        rx_inject(8'h55);
        rx_inject(8'hAA);
        for (int i = 0; i < 3; i++) begin
            bus_read(2'd0, d, v);
            checks += 2;
            if (v !== 1'b1) begin failures++; $display("FAIL rx_read%0d_rvalid got=%b exp=1", i, v); end
            if (d !== exp_d[i]) begin failures++; $display("FAIL rx_read%0d_data got=%h exp=%h", i, d, exp_d[i]); end
            tick();
            checks++;
            if (bus_if.bus_rvalid !== 1'b0) begin failures++; $display("FAIL rx_read%0d_pulse got=%b exp=0", i, bus_if.bus_rvalid); end
        end
    endtask

    task automatic test_rx_backpressure();
        logic [7:0]  b [20];
        logic [31:0] d;
        logic        v, acc;
        int          k;
        for (int i = 0; i < 20; i++) b[i] = 8'($urandom);
        k = 0;
        bus_if.rx_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus_if.rx_data = b[k];
            acc = bus_if.rx_ready;
            tick();
            if (acc) k++;
        end
        checks += 2;
        if (k != 16) begin failures++; $display("FAIL rxbp_accepted got=%0d exp=16", k); end
        if (bus_if.rx_ready !== 1'b0) begin failures++; $display("FAIL rxbp_full got=%b exp=0", bus_if.rx_ready); end
        bus_if.rx_data = b[16];
        bus_read(2'd0, d, v);
        checks += 2;
        if (d !== {1'b1, 23'b0, b[0]}) begin failures++; $display("FAIL rxbp_first got=%h exp=%h", d, {1'b1, 23'b0, b[0]}); end
        if (bus_if.rx_ready !== 1'b1) begin failures++; $display("FAIL rxbp_reopen got=%b exp=1", bus_if.rx_ready); end
        tick();
        bus_if.rx_valid = 1'b0;
        checks++;
        if (bus_if.rx_ready !== 1'b0) begin failures++; $display("FAIL rxbp_byte17 got=%b exp=0", bus_if.rx_ready); end
        for (int i = 1; i <= 17; i++) begin
            bus_read(2'd0, d, v);
            checks++;
            if (i <= 16 && d !== {1'b1, 23'b0, b[i]}) begin
                failures++; $display("FAIL rxbp_drain%0d got=%h exp=%h", i, d, {1'b1, 23'b0, b[i]});
            end else if (i == 17 && d !== 32'h0) begin
                failures++; $display("FAIL rxbp_drain_empty got=%h exp=0", d);
            end
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic        v;
        bus_write(2'd2, 32'h1);
        checks++;
        if (bus_if.irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b exp=0", bus_if.irq); end
        rx_inject(8'($urandom));
        checks++;
        if (bus_if.irq !== 1'b0) begin failures++; $display("FAIL irq_push_edge got=%b exp=0", bus_if.irq); end
        tick();
        checks++;
        if (bus_if.irq !== 1'b1) begin failures++; $display("FAIL irq_rx_set got=%b exp=1", bus_if.irq); end
        bus_read(2'd0, d, v);
        checks += 2;
        if (d !== m_rdata) begin failures++; $display("FAIL irq_rx_data got=%h exp=%h", d, m_rdata); end
        if (bus_if.irq !== 1'b1) begin failures++; $display("FAIL irq_pop_edge got=%b exp=1", bus_if.irq); end
        tick();
        checks++;
        if (bus_if.irq !== 1'b0) begin failures++; $display("FAIL irq_rx_clear got=%b exp=0", bus_if.irq); end
        bus_write(2'd2, 32'hFFFF_FFF2);
        tick();
        checks++;
        if (bus_if.irq !== 1'b1) begin failures++; $display("FAIL irq_txe got=%b exp=1", bus_if.irq); end
        bus_read(2'd2, d, v);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL ctrl_readback got=%h exp=2", d); end
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, d, v);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reserved_read got=%h exp=0", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        v;
        bus_if.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) bus_write(2'd0, 32'($urandom));
        bus_write(2'd2, 32'h3);
        bus_if.tx_ready = 1'b1;
        tick();
        tick();
        rst             = 1'b1;
        bus_if.bus_rd   = 1'b1;
        bus_if.bus_addr = 2'd1;
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'($urandom);
        tick();
        rst             = 1'b0;
        bus_if.bus_rd   = 1'b0;
        bus_if.rx_valid = 1'b0;
        checks += 3;
        if (bus_if.bus_rvalid !== 1'b0) begin failures++; $display("FAIL rstmid_rvalid got=%b exp=0", bus_if.bus_rvalid); end
        if (bus_if.tx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_tx_valid got=%b exp=0", bus_if.tx_valid); end
        if (bus_if.irq !== 1'b0) begin failures++; $display("FAIL rstmid_irq got=%b exp=0", bus_if.irq); end
        bus_read(2'd1, d, v);
        checks++;
        if (d !== 32'h0000_0002) begin failures++; $display("FAIL rstmid_status got=%h exp=00000002", d); end
        bus_read(2'd2, d, v);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL rstmid_ctrl got=%h exp=0", d); end
        tick();
        checks++;
        if (bus_if.irq !== 1'b0) begin failures++; $display("FAIL rstmid_irq_after got=%b exp=0", bus_if.irq); end
    endtask

    task automatic test_random();
        int ph, r;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks += 4;
            if (bus_if.tx_valid !== (tx_q.size() != 0)) begin failures++; $display("FAIL rnd_tx_valid cyc=%0d got=%b exp=%b", cyc, bus_if.tx_valid, tx_q.size() != 0); end
            if (bus_if.rx_ready !== (rx_q.size() != DEPTH)) begin failures++; $display("FAIL rnd_rx_ready cyc=%0d got=%b exp=%b", cyc, bus_if.rx_ready, rx_q.size() != DEPTH); end
            if (bus_if.irq !== m_irq) begin failures++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", cyc, bus_if.irq, m_irq); end
            if (bus_if.bus_rvalid !== m_rvalid) begin failures++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, bus_if.bus_rvalid, m_rvalid); end
            if (m_rvalid) begin
                checks++;
                if (bus_if.bus_rdata !== m_rdata) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bus_if.bus_rdata, m_rdata); end
            end
            if (tx_q.size() != 0) begin
                checks++;
                if (bus_if.tx_data !== tx_q[0]) begin failures++; $display("FAIL rnd_tx_data cyc=%0d got=%h exp=%h", cyc, bus_if.tx_data, tx_q[0]); end
            end
            // Phases bias traffic toward TX overflow, TX drain, RX fill and RX drain.
            ph = (cyc / 150) % 4;
            r  = int'($urandom_range(0, 99));
            bus_if.tx_ready  = (ph == 1) ? (r < 80) : (r < 10);
            bus_if.rx_valid  = (ph == 2) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            bus_if.rx_data   = 8'($urandom);
            bus_if.bus_addr  = 2'($urandom_range(0, 3));
            bus_if.bus_wdata = $urandom;
            r = int'($urandom_range(0, 99));
            bus_if.bus_wr = 1'b0;
            bus_if.bus_rd = 1'b0;
            if (ph == 0 && r < 60) begin
                bus_if.bus_wr   = 1'b1;
                bus_if.bus_addr = ($urandom_range(0, 3) != 0) ? 2'd0 : 2'($urandom_range(1, 3));
            end else if (ph == 3 && r < 60) begin
                bus_if.bus_rd = 1'b1;
            end else if (r < 20) begin
                bus_if.bus_wr = 1'b1;
            end else if (r < 40) begin
                bus_if.bus_rd = 1'b1;
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst             = 1'b0;
        bus_if.bus_wr   = 1'b0;
        bus_if.bus_rd   = 1'b0;
        bus_if.rx_valid = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.bus_addr  = 2'd0;
        bus_if.bus_wr    = 1'b0;
        bus_if.bus_wdata = 32'h0;
        bus_if.bus_rd    = 1'b0;
        bus_if.tx_ready  = 1'b0;
        bus_if.rx_valid  = 1'b0;
        bus_if.rx_data   = 8'h0;
        m_ovf            = 1'b0;
        m_ctrl           = 2'b00;
        m_irq            = 1'b0;
        m_rvalid         = 1'b0;
        m_rdata          = 32'h0;
        test_reset();
        test_tx_order();
        test_tx_full();
        test_rx_read();
        test_rx_backpressure();
        test_irq();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
